// File: rtl/alu_arbiter.sv
// alu_arbiter: two-requester round-robin front end for one shared combinational ALU.
// Each accepted operation is latched into the ALU operand registers, executed for one
// cycle, and its result is held on the response port until the consumer takes it.
module alu_arbiter #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned OPW   = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic [OPW-1:0]   req0_op,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    input  logic [OPW-1:0]   req1_op,
    output logic             resp_valid,
    input  logic             resp_ready,
    output logic [WIDTH-1:0] resp_data,
    output logic             resp_id,
    output logic             busy,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [OPW-1:0]   alu_op,
    input  logic [WIDTH-1:0] alu_c
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_EXEC = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    logic [1:0]       state_q, state_d;
    logic             last_grant_q, last_grant_d;
    logic             resp_valid_q, resp_valid_d;
    logic [WIDTH-1:0] resp_data_q, resp_data_d;
    logic             resp_id_q, resp_id_d;
    logic [WIDTH-1:0] alu_a_q, alu_a_d;
    logic [WIDTH-1:0] alu_b_q, alu_b_d;
    logic [OPW-1:0]   alu_op_q, alu_op_d;
    // Cleared by reset, set on the first clock after release; keeps both ready
    // outputs low while reset is asserted without using reset as a data signal.
    logic             armed_q;

    logic grant;
    logic accept;
    logic idle;

    // Arbitration: a lone requester wins; on a tie the one not granted last time wins.
    always_comb begin
        grant = 1'b0;
        if (req0_valid && req1_valid) begin
            grant = ~last_grant_q;
        end else if (req1_valid) begin
            grant = 1'b1;
        end
    end

    // Ready is only offered in IDLE, to the current winner.
    always_comb begin
        idle       = (state_q == ST_IDLE) && armed_q;
        req0_ready = idle && req0_valid && !grant;
        req1_ready = idle && req1_valid && grant;
        accept     = req0_ready || req1_ready;
    end

    // Sequencer next-state and datapath register updates.
    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        resp_valid_d = resp_valid_q;
        resp_data_d  = resp_data_q;
        resp_id_d    = resp_id_q;
        alu_a_d      = alu_a_q;
        alu_b_d      = alu_b_q;
        alu_op_d     = alu_op_q;
        unique case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    alu_a_d      = grant ? req1_a  : req0_a;
                    alu_b_d      = grant ? req1_b  : req0_b;
                    alu_op_d     = grant ? req1_op : req0_op;
                    resp_id_d    = grant;
                    last_grant_d = grant;
                    state_d      = ST_EXEC;
                end
            end
            ST_EXEC: begin
                resp_data_d  = alu_c;
                resp_valid_d = 1'b1;
                state_d      = ST_RESP;
            end
            ST_RESP: begin
                if (resp_ready) begin
                    resp_valid_d = 1'b0;
                    state_d      = ST_IDLE;
                end
            end
            default: begin
                resp_valid_d = 1'b0;
                state_d      = ST_IDLE;
            end
        endcase
    end

    // State registers; reset aborts any transaction in flight.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= ST_IDLE;
            last_grant_q <= 1'b1;
            resp_valid_q <= 1'b0;
            resp_data_q  <= '0;
            resp_id_q    <= 1'b0;
            alu_a_q      <= '0;
            alu_b_q      <= '0;
            alu_op_q     <= '0;
            armed_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            resp_valid_q <= resp_valid_d;
            resp_data_q  <= resp_data_d;
            resp_id_q    <= resp_id_d;
            alu_a_q      <= alu_a_d;
            alu_b_q      <= alu_b_d;
            alu_op_q     <= alu_op_d;
            armed_q      <= 1'b1;
        end
    end

    // Output mapping.
    always_comb begin
        resp_valid = resp_valid_q;
        resp_data  = resp_data_q;
        resp_id    = resp_id_q;
        busy       = (state_q != ST_IDLE);
        alu_a      = alu_a_q;
        alu_b      = alu_b_q;
        alu_op     = alu_op_q;
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: directed tests for alu_arbiter with a small external ALU model.
module tb_alu_arbiter;

    localparam int unsigned WIDTH = 32;
    localparam int unsigned OPW   = 3;

    logic             clk;
    logic             reset;
    logic             req0_valid, req0_ready;
    logic [WIDTH-1:0] req0_a, req0_b;
    logic [OPW-1:0]   req0_op;
    logic             req1_valid, req1_ready;
    logic [WIDTH-1:0] req1_a, req1_b;
    logic [OPW-1:0]   req1_op;
    logic             resp_valid, resp_ready;
    logic [WIDTH-1:0] resp_data;
    logic             resp_id;
    logic             busy;
    logic [WIDTH-1:0] alu_a, alu_b, alu_c;
    logic [OPW-1:0]   alu_op;

    int checks = 0;
    int errors = 0;

    alu_arbiter #(.WIDTH(WIDTH), .OPW(OPW)) dut (
        .clk        (clk),
        .reset      (reset),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_a     (req0_a),
        .req0_b     (req0_b),
        .req0_op    (req0_op),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_a     (req1_a),
        .req1_b     (req1_b),
        .req1_op    (req1_op),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_data  (resp_data),
        .resp_id    (resp_id),
        .busy       (busy),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_op     (alu_op),
        .alu_c      (alu_c)
    );

    // ALU model: 000 add, 001 sub, 010 and, 011 or, others xor.
    always_comb begin
        case (alu_op)
            3'b000:  alu_c = alu_a + alu_b;
            3'b001:  alu_c = alu_a - alu_b;
            3'b010:  alu_c = alu_a & alu_b;
            3'b011:  alu_c = alu_a | alu_b;
            default: alu_c = alu_a ^ alu_b;
        endcase
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not reach the summary");
        $fatal(1, "watchdog expired");
    end

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        req0_valid = 1'b0; req0_a = '0; req0_b = '0; req0_op = '0;
        req1_valid = 1'b0; req1_a = '0; req1_b = '0; req1_op = '0;
        resp_ready = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset = 1'b0;
        tick();
        tick();
        reset = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        idle_inputs();
        reset = 1'b0;
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        #1;
        checks++; if (resp_valid !== 1'b0) begin errors++;
            $display("FAIL reset_resp_valid: got %b want 0", resp_valid); end
        checks++; if (resp_data !== '0) begin errors++;
            $display("FAIL reset_resp_data: got %0d want 0", resp_data); end
        checks++; if (resp_id !== 1'b0) begin errors++;
            $display("FAIL reset_resp_id: got %b want 0", resp_id); end
        checks++; if (busy !== 1'b0) begin errors++;
            $display("FAIL reset_busy: got %b want 0", busy); end
        checks++; if ({alu_a, alu_b, alu_op} !== '0) begin errors++;
            $display("FAIL reset_alu_regs: got %0h/%0h/%0h want 0", alu_a, alu_b, alu_op); end
        checks++; if ({req0_ready, req1_ready} !== 2'b00) begin errors++;
            $display("FAIL reset_ready: got %b want 00", {req0_ready, req1_ready}); end
        do_reset();
    endtask

    // Single requester: 5 + 63 = 68 with id 0.
    task automatic test_single();
        req0_valid = 1'b1; req0_a = 5; req0_b = 63; req0_op = 3'b000;
        resp_ready = 1'b1;
        #1;
        checks++; if (req0_ready !== 1'b1 || busy !== 1'b0) begin errors++;
            $display("FAIL single_accept: got ready=%b busy=%b want 1/0", req0_ready, busy); end
        tick();
        req0_valid = 1'b0;
        #1;
        checks++; if (busy !== 1'b1 || resp_valid !== 1'b0 || req0_ready !== 1'b0) begin errors++;
            $display("FAIL single_exec: got busy=%b rv=%b rdy=%b want 1/0/0",
                     busy, resp_valid, req0_ready); end
        checks++; if (alu_a !== 32'd5 || alu_b !== 32'd63 || alu_op !== 3'b000) begin errors++;
            $display("FAIL single_alu_regs: got %0d/%0d/%0d want 5/63/0", alu_a, alu_b, alu_op); end
        tick();
        #1;
        checks++; if (resp_valid !== 1'b1 || resp_data !== 32'd68 || resp_id !== 1'b0
                      || busy !== 1'b1) begin errors++;
            $display("FAIL single_resp: got rv=%b data=%0d id=%b busy=%b want 1/68/0/1",
                     resp_valid, resp_data, resp_id, busy); end
        tick();
        #1;
        checks++; if (resp_valid !== 1'b0 || busy !== 1'b0) begin errors++;
            $display("FAIL single_done: got rv=%b busy=%b want 0/0", resp_valid, busy); end
        idle_inputs();
    endtask

    // First tie after reset goes to req0 (79 - 63 = 16), then req1 (5 + 63 = 68).
    task automatic test_tie();
        do_reset();
        req0_valid = 1'b1; req0_a = 79; req0_b = 63; req0_op = 3'b001;
        req1_valid = 1'b1; req1_a = 5;  req1_b = 63; req1_op = 3'b000;
        resp_ready = 1'b1;
        #1;
        checks++; if ({req0_ready, req1_ready} !== 2'b10) begin errors++;
            $display("FAIL tie_first_grant: got %b want 10", {req0_ready, req1_ready}); end
        tick();
        req0_valid = 1'b0;
        tick();
        #1;
        checks++; if (resp_valid !== 1'b1 || resp_data !== 32'd16 || resp_id !== 1'b0) begin
            errors++;
            $display("FAIL tie_resp0: got rv=%b data=%0d id=%b want 1/16/0",
                     resp_valid, resp_data, resp_id); end
        tick();
        #1;
        checks++; if ({req0_ready, req1_ready} !== 2'b01) begin errors++;
            $display("FAIL tie_second_grant: got %b want 01", {req0_ready, req1_ready}); end
        tick();
        req1_valid = 1'b0;
        tick();
        #1;
        checks++; if (resp_valid !== 1'b1 || resp_data !== 32'd68 || resp_id !== 1'b1) begin
            errors++;
            $display("FAIL tie_resp1: got rv=%b data=%0d id=%b want 1/68/1",
                     resp_valid, resp_data, resp_id); end
        tick();
        idle_inputs();
    endtask

    // Both valid continuously: ids alternate 0,1,0,1 and accepts are 3 cycles apart.
    task automatic test_back_to_back();
        int n_acc, n_rsp;
        int acc_cyc[8];
        logic acc_id[8];
        logic rsp_id_seen[8];
        logic [WIDTH-1:0] rsp_val[8];
        logic [WIDTH-1:0] exp_val;
        n_acc = 0;
        n_rsp = 0;
        req0_valid = 1'b1; req0_a = 10; req0_b = 3; req0_op = 3'b010;
        req1_valid = 1'b1; req1_a = 10; req1_b = 3; req1_op = 3'b011;
        resp_ready = 1'b1;
        for (int i = 0; i < 12; i++) begin
            #1;
            if ((req0_ready || req1_ready) && n_acc < 8) begin
                acc_cyc[n_acc] = i;
                acc_id[n_acc]  = req1_ready;
                n_acc++;
            end
            if (resp_valid && n_rsp < 8) begin
                rsp_id_seen[n_rsp] = resp_id;
                rsp_val[n_rsp]     = resp_data;
                n_rsp++;
            end
            tick();
        end
        idle_inputs();
        checks++; if (n_acc !== 4 || n_rsp !== 4) begin errors++;
            $display("FAIL b2b_counts: got acc=%0d rsp=%0d want 4/4", n_acc, n_rsp); end
        for (int k = 0; k < 4; k++) begin
            if (k < n_acc && k < n_rsp) begin
                exp_val = (k % 2 == 0) ? 32'd2 : 32'd11;
                checks++; if (acc_id[k] !== k[0] || rsp_id_seen[k] !== k[0]) begin errors++;
                    $display("FAIL b2b_id%0d: got acc=%b rsp=%b want %b",
                             k, acc_id[k], rsp_id_seen[k], k[0]); end
                checks++; if (rsp_val[k] !== exp_val) begin errors++;
                    $display("FAIL b2b_data%0d: got %0d want %0d", k, rsp_val[k], exp_val); end
            end
            if (k > 0 && k < n_acc) begin
                checks++; if (acc_cyc[k] - acc_cyc[k-1] !== 3) begin errors++;
                    $display("FAIL b2b_spacing%0d: got %0d want 3",
                             k, acc_cyc[k] - acc_cyc[k-1]); end
            end
        end
    endtask

    // Consumer stalls for 5 cycles: response held, no new accept.
    task automatic test_stall();
        req0_valid = 1'b1; req0_a = 1; req0_b = 2; req0_op = 3'b000;
        resp_ready = 1'b0;
        tick();
        tick();
        req1_valid = 1'b1; req1_a = 7; req1_b = 7; req1_op = 3'b000;
        for (int i = 0; i < 5; i++) begin
            #1;
            checks++; if (resp_valid !== 1'b1 || resp_data !== 32'd3 || resp_id !== 1'b0
                          || {req0_ready, req1_ready} !== 2'b00) begin errors++;
                $display("FAIL stall_hold%0d: got rv=%b data=%0d id=%b rdy=%b want 1/3/0/00",
                         i, resp_valid, resp_data, resp_id, {req0_ready, req1_ready}); end
            tick();
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        resp_ready = 1'b1;
        tick();
        #1;
        checks++; if (resp_valid !== 1'b0 || busy !== 1'b0) begin errors++;
            $display("FAIL stall_release: got rv=%b busy=%b want 0/0", resp_valid, busy); end
        idle_inputs();
    endtask

    // Reset in EXEC aborts the transaction and restores the req0 tie preference.
    task automatic test_reset_mid();
        int seen;
        seen = 0;
        req0_valid = 1'b1; req0_a = 100; req0_b = 1; req0_op = 3'b000;
        req1_valid = 1'b1; req1_a = 200; req1_b = 1; req1_op = 3'b000;
        resp_ready = 1'b1;
        tick();
        #1;
        reset = 1'b0;
        #1;
        checks++; if (resp_valid !== 1'b0 || resp_data !== '0 || resp_id !== 1'b0
                      || busy !== 1'b0 || {alu_a, alu_b, alu_op} !== '0
                      || {req0_ready, req1_ready} !== 2'b00) begin errors++;
            $display("FAIL midreset_outputs: got rv=%b data=%0d id=%b busy=%b a=%0d rdy=%b want 0",
                     resp_valid, resp_data, resp_id, busy, alu_a, {req0_ready, req1_ready}); end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        tick();
        reset = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (resp_valid || busy) seen++;
        end
        checks++; if (seen !== 0) begin errors++;
            $display("FAIL midreset_no_resp: got %0d active cycles want 0", seen); end
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        #1;
        checks++; if ({req0_ready, req1_ready} !== 2'b10) begin errors++;
            $display("FAIL midreset_tie: got %b want 10", {req0_ready, req1_ready}); end
        tick();
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        tick();
        tick();
        idle_inputs();
    endtask

    // req1 pulses valid while busy and withdraws: never accepted, no response.
    task automatic test_drop();
        int rdy1, rsp1, busy_cnt;
        rdy1 = 0; rsp1 = 0; busy_cnt = 0;
        req0_valid = 1'b1; req0_a = 9; req0_b = 4; req0_op = 3'b001;
        resp_ready = 1'b1;
        tick();
        req0_valid = 1'b0;
        req1_valid = 1'b1; req1_a = 1; req1_b = 1; req1_op = 3'b000;
        #1;
        if (req1_ready) rdy1++;
        tick();
        req1_valid = 1'b0;
        #1;
        checks++; if (resp_valid !== 1'b1 || resp_data !== 32'd5 || resp_id !== 1'b0) begin
            errors++;
            $display("FAIL drop_req0_resp: got rv=%b data=%0d id=%b want 1/5/0",
                     resp_valid, resp_data, resp_id); end
        for (int i = 0; i < 6; i++) begin
            tick();
            #1;
            if (req1_ready) rdy1++;
            if (resp_valid && resp_id) rsp1++;
            if (busy) busy_cnt++;
        end
        checks++; if (rdy1 !== 0 || rsp1 !== 0 || busy_cnt !== 0) begin errors++;
            $display("FAIL drop_ignored: got rdy=%0d rsp=%0d busy=%0d want 0/0/0",
                     rdy1, rsp1, busy_cnt); end
        idle_inputs();
    endtask

    initial begin
        idle_inputs();
        reset = 1'b0;
        tick();
        test_reset();
        test_single();
        test_tie();
        test_back_to_back();
        test_stall();
        test_reset_mid();
        test_drop();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
